// File: rtl/spi_pkg.sv
// Shared frame constants, default slave IDs and FSM encoding for the SPI responder.
package spi_pkg;

  localparam int unsigned ID_BITS    = 8;
  localparam int unsigned ADDR_BITS  = 8;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = ID_BITS + ADDR_BITS + DATA_BITS;

  localparam logic [7:0] DEF_SLAVE_IDW = 8'hFF;
  localparam logic [7:0] DEF_SLAVE_IDR = 8'h00;

  localparam int unsigned CNT_W = 5;
  // Rise counts (taken before the increment) at which each field completes.
  localparam logic [CNT_W-1:0] LAST_ID_CNT    = CNT_W'(ID_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_ADDR_CNT  = CNT_W'(ID_BITS + ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] TX_LOAD_CNT    = CNT_W'(ID_BITS + ADDR_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID,
    S_ADDR,
    S_DATA,
    S_WAIT_END,
    S_IGNORE
  } state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage input synchronizer with optional rise/fall detection on the
// two most recent synchronized samples.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0,
  parameter bit          EDGE_DETECT = 1'b1
) (
  input  logic clock,
  input  logic n_reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else          sync_q <= sync_d;
  end

  assign dout = sync_q[SYNC_STAGES-1];

  if (EDGE_DETECT) begin : g_edge
    logic prev_q, prev_d;

    always_comb begin
      prev_d = dout;
    end

    always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) prev_q <= RESET_VAL;
      else          prev_q <= prev_d;
    end

    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder for 24-bit ID/address/data frames: decodes writes into
// a one-cycle strobe and serves reads from an external register bank.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [7:0]  SLAVE_IDW   = DEF_SLAVE_IDW,
  parameter logic [7:0]  SLAVE_IDR   = DEF_SLAVE_IDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       frame_err
);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_s_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_DETECT(1'b1)) u_ss_sync (
    .clock(clock), .n_reset(n_reset), .din(ss),
    .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DETECT(1'b1)) u_sclk_sync (
    .clock(clock), .n_reset(n_reset), .din(sclk),
    .dout(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DETECT(1'b0)) u_mosi_sync (
    .clock(clock), .n_reset(n_reset), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       rx_q, rx_d, rx_next;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       tx_q, tx_d;
  logic             rw_q, rw_d;
  logic             rd_cap_q, rd_cap_d;
  logic             miso_q, miso_d;
  logic             wr_valid_q, wr_valid_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             rd_req_q, rd_req_d;
  logic [7:0]       rd_addr_q, rd_addr_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    miso_d      = miso_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    frame_err_d = 1'b0;
    // rd_data is valid the cycle after rd_req, so capture one cycle behind it.
    rd_cap_d    = rd_req_q;
    rx_next     = {rx_q[6:0], mosi_s};

    if (rd_cap_q) tx_d = rd_data;

    unique case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          state_d = S_ID;
          rx_d    = '0;
        end
      end
      S_ID: begin
        if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == LAST_ID_CNT) begin
            if (rx_next == SLAVE_IDW) begin
              rw_d    = 1'b1;
              state_d = S_ADDR;
            end else if (rx_next == SLAVE_IDR) begin
              rw_d    = 1'b0;
              state_d = S_ADDR;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_IGNORE;
            end
          end
        end
      end
      S_ADDR: begin
        if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == LAST_ADDR_CNT) begin
            addr_d  = rx_next;
            state_d = S_DATA;
            if (!rw_q) begin
              rd_req_d  = 1'b1;
              rd_addr_d = rx_next;
            end
          end
        end
      end
      S_DATA: begin
        if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == LAST_FRAME_CNT) begin
            state_d = S_WAIT_END;
            if (rw_q) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = rx_next;
            end
          end
        end else if (sclk_fall && !rw_q) begin
          if (bit_cnt_q == TX_LOAD_CNT) begin
            miso_d = tx_q[7];
          end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            miso_d = tx_q[6];
          end
        end
      end
      S_WAIT_END: begin
        if (sclk_fall) miso_d = 1'b0;
      end
      S_IGNORE: begin
        miso_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (ss_rise) begin
      state_d     = S_IDLE;
      frame_err_d = state_q inside {S_ID, S_ADDR, S_DATA};
    end

    if (ss_s) begin
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      rd_cap_q    <= 1'b0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      rd_cap_q    <= rd_cap_d;
      miso_q      <= miso_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = miso_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder for the 24-bit write/read frame issued by the team's SPI master: 8-bit slave ID, then 8-bit register address, then 8-bit data.
- Mode 0, MSB first, ss active-low.
- Oversamples ss/sclk/mosi on the system clock and decodes the frame.
- Write frames produce a register-write strobe; read frames fetch a byte from an external register bank and shift it out on miso.

Parameters:
- SLAVE_IDW, 8'hFF, ID byte selecting a write frame
- SLAVE_IDR, 8'h00, ID byte selecting a read frame
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2)

Ports:
- clock  in  1  system clock
- n_reset  in  1  asynchronous, active-low reset
- ss  in  1  slave select, active low, asynchronous to clock
- sclk  in  1  serial clock, idle low, asynchronous
- mosi  in  1  serial data in
- miso  out  1  serial data out
- wr_valid  out  1  one-cycle write strobe
- wr_addr  out  8  write address, valid with wr_valid
- wr_data  out  8  write data, valid with wr_valid
- rd_req  out  1  one-cycle read request
- rd_addr  out  8  read address, valid with rd_req
- rd_data  in  8  read data, valid exactly 1 cycle after rd_req
- busy  out  1  high from ss fall until ss rise is detected
- frame_err  out  1  one-cycle pulse on aborted or bad-ID frame

Behaviour:
- Reset (async, active-low): all outputs 0, FSM to IDLE, shift registers and counters cleared, synchronizer flops cleared to ss=1, sclk=0, mosi=0.
- Inputs pass through SYNC_STAGES flops. Edges are detected from the last two synchronized samples.
- Detection latency: SYNC_STAGES+1 clocks from the pin.
- Timing requirement: the master's sclk half-period must be at least 7 clocks (master freq ≥ 6). Not checked by the block.
- Sampling: mosi is sampled on each detected sclk rise while ss is low. bit_cnt (0..23) increments per rise.
- miso changes only on detected sclk falls, or when ss rises.
- FSM states: IDLE, ID, ADDR, DATA, WAIT_END, IGNORE.
- IDLE -> ID on detected ss fall.
- busy is high in every state except IDLE.
- ID: shift in 8 bits. After rise #7:
  - ID == SLAVE_IDW -> ADDR, rw=1
  - ID == SLAVE_IDR -> ADDR, rw=0
  - otherwise -> IGNORE; frame_err pulses 1 cycle later
- ADDR: shift in 8 bits. On the cycle after rise #15:
  - read frame: rd_req=1 for 1 cycle, rd_addr = address
  - rd_data is captured into tx_shift the following cycle
  - -> DATA
- DATA, read frame:
  - miso = tx_shift[7] from the sclk fall after rise #15
  - tx_shift shifts left on falls after rises #16..#22
  - miso forced to 0 on the fall after rise #23
  - mosi bits are sampled but discarded
- DATA, write frame:
  - shift in 8 bits; miso held at 0
  - the cycle after rise #23: wr_valid=1 for 1 cycle; wr_addr/wr_data hold the frame values and keep them until the next write
- After rise #23 -> WAIT_END. Further sclk edges are ignored until ss rises.
- IGNORE: all sclk edges ignored and miso held at 0 until ss rises.
- ss rise detected in ID, ADDR or DATA (short frame):
  - abort, no wr_valid, frame_err pulse, -> IDLE
  - a pending rd_req that has already issued is not retracted
- ss rise in WAIT_END or IGNORE: -> IDLE, no error.
- ss high: miso=0 and bit_cnt=0, in every state.
- ss fall while busy is not possible without an intervening rise. A new frame requires a detected ss rise followed by a detected ss fall.
- A master read frame sends wdata bits as 0. The block does not check this.

Decomposition:
- Shared package spi_pkg, holding:
  - frame constants: ID_BITS=8, ADDR_BITS=8, DATA_BITS=8, FRAME_BITS=24
  - default IDs 8'hFF / 8'h00
  - FSM state encoding
- One sub-module spi_in_sync: SYNC_STAGES-deep synchronizer plus rise/fall detect. Instantiated for ss and sclk, and for mosi without edge outputs.

Test Plan:
- Write: master freq=10, start_wr, addr=8'h3C, wdata=8'hA5 -> exactly one wr_valid, wr_addr=8'h3C, wr_data=8'hA5; miso stays 0; frame_err=0; busy falls after ss rises.
- Read: register model returns 8'h5A for addr 8'h12; master start_re, freq=10 -> rd_req once with rd_addr=8'h12; master rdata=8'h5A; no wr_valid.
- Bad ID: frame with ID 8'h81 -> frame_err one pulse; no rd_req or wr_valid; miso 0 throughout.
- Abort: ss raised after 12 sclk rises -> frame_err pulse, FSM in IDLE; the next normal write (addr 8'h01, data 8'hFF) completes correctly.
- Minimum timing: freq=6, read addr 8'hFE returning 8'h81 -> master rdata=8'h81. Back-to-back write then read frames both complete.
- Reset: n_reset asserted mid-DATA -> miso, wr_valid, rd_req, busy, frame_err all 0 immediately; after release, no strobe until a full new frame.
